// File: rtl/hpdl1414_pkg.sv
// Shared definitions for the HPDL-1414 writer: FSM states, character codes and
// the mapping from a screen position (0 = leftmost) to display select and digit address.
package hpdl1414_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        NEXT
    } state_t;

    localparam int          NUM_POS    = 16;
    localparam logic [7:0]  CHAR_CR    = 8'h0D;
    localparam logic [7:0]  CHAR_FF    = 8'h0C;
    localparam logic [6:0]  CHAR_SPACE = 7'h20;

    typedef struct packed {
        logic [1:0] disp;
        logic [1:0] addr;
    } pos_map_t;

    // Each HPDL-1414 numbers its digits right to left, so the address is mirrored.
    function automatic pos_map_t map_pos(input logic [3:0] pos);
        pos_map_t m;
        m.disp = pos[3:2];
        m.addr = 2'd3 - pos[1:0];
        return m;
    endfunction

    function automatic logic [7:0] fold_case(input logic [7:0] c);
        return (c >= 8'h60 && c <= 8'h7E) ? c - 8'h20 : c;
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h5F);
    endfunction

endpackage

// File: rtl/hpdl1414_strobe.sv
// Single-position bus write: SETUP_CYC cycles of address/data, WR_CYC cycles of one
// WR line low, HOLD_CYC cycles of hold. A start in idle launches it; done pulses in the last hold cycle.
module hpdl1414_strobe #(
    parameter int SETUP_CYC = 2,
    parameter int WR_CYC    = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] data,
    input  logic [1:0] addr,
    input  logic [1:0] disp,
    output logic [6:0] hpdl_d,
    output logic [1:0] hpdl_a,
    output logic [3:0] hpdl_wr_n,
    output logic       done
);
    import hpdl1414_pkg::*;

    state_t      phase;
    logic [15:0] cnt;
    logic [1:0]  disp_q;

    assign done = (phase == HOLD) && (cnt == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase     <= IDLE;
            cnt       <= '0;
            disp_q    <= '0;
            hpdl_d    <= '0;
            hpdl_a    <= '0;
            hpdl_wr_n <= 4'hF;
        end else begin
            case (phase)
                IDLE: begin
                    if (start) begin
                        phase  <= SETUP;
                        cnt    <= 16'(SETUP_CYC - 1);
                        hpdl_d <= data;
                        hpdl_a <= addr;
                        disp_q <= disp;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        phase     <= STROBE;
                        cnt       <= 16'(WR_CYC - 1);
                        hpdl_wr_n <= ~(4'b0001 << disp_q);
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        phase     <= HOLD;
                        cnt       <= 16'(HOLD_CYC - 1);
                        hpdl_wr_n <= 4'hF;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        phase  <= IDLE;
                        hpdl_d <= '0;
                        hpdl_a <= '0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: begin
                    phase     <= IDLE;
                    hpdl_wr_n <= 4'hF;
                end
            endcase
        end
    end

endmodule

// File: rtl/hpdl1414_writer.sv
// Terminal-style writer for four HPDL-1414 displays fed by a byte stream.
// Define HPDL_SCROLL_EN to scroll the line left when a character arrives at the end instead of wrapping.
module hpdl1414_writer #(
    parameter int SETUP_CYC = 2,
    parameter int WR_CYC    = 3,
    parameter int HOLD_CYC  = 2
) (
    input  logic       CLK_i,
    input  logic       RST_i,
    input  logic [7:0] char_i,
    input  logic       char_valid_i,
    output logic       char_ready_o,
    output logic [6:0] hpdl_d_o,
    output logic [1:0] hpdl_a_o,
    output logic [3:0] hpdl_wr_n_o,
    output logic       busy_o
);
    import hpdl1414_pkg::*;

    state_t     state;
    logic [6:0] buffer [NUM_POS];
    logic [4:0] cursor;
    logic [3:0] pos;
    logic       rewrite_all;

    logic [7:0] folded;
    logic       is_print;
    logic       single_write;
    logic [3:0] wr_pos;

    logic       start;
    logic [3:0] start_pos;
    logic [6:0] start_data;
    pos_map_t   start_map;
    logic       done;

    assign folded   = fold_case(char_i);
    assign is_print = is_printable(folded);
    assign wr_pos   = (cursor == 5'd16) ? 4'd0 : cursor[3:0];

`ifdef HPDL_SCROLL_EN
    assign single_write = is_print && (cursor != 5'd16);
`else
    assign single_write = is_print;
`endif

    assign char_ready_o = (state == IDLE);
    assign busy_o       = (state != IDLE);

    // The strober is launched in the acceptance cycle so d/a appear one cycle after the transfer.
    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        start      = 1'b0;
        start_pos  = pos;
        start_data = buffer[pos];
        case (state)
            INIT, NEXT: start = 1'b1;
            IDLE: begin
                if (char_valid_i && single_write) begin
                    start      = 1'b1;
                    start_pos  = wr_pos;
                    start_data = folded[6:0];
                end
            end
            default: ;
        endcase
    end

    assign start_map = map_pos(start_pos);

    hpdl1414_strobe #(
        .SETUP_CYC (SETUP_CYC),
        .WR_CYC    (WR_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) u_strobe (
        .clk       (CLK_i),
        .rst       (RST_i),
        .start     (start),
        .data      (start_data),
        .addr      (start_map.addr),
        .disp      (start_map.disp),
        .hpdl_d    (hpdl_d_o),
        .hpdl_a    (hpdl_a_o),
        .hpdl_wr_n (hpdl_wr_n_o),
        .done      (done)
    );

    // SETUP here means "write in flight": the strober walks its own SETUP/STROBE/HOLD phases.
    // NOTE: the shadow buffer is reset on purpose so INIT can blank the displays straight from it.
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state       <= INIT;
            cursor      <= '0;
            pos         <= '0;
            rewrite_all <= 1'b1;
            for (int i = 0; i < NUM_POS; i++) buffer[i] <= CHAR_SPACE;
        end else begin
            case (state)
                INIT: begin
                    pos         <= '0;
                    rewrite_all <= 1'b1;
                    state       <= SETUP;
                end
                IDLE: begin
                    if (char_valid_i) begin
                        if (single_write) begin
                            buffer[wr_pos] <= folded[6:0];
                            cursor         <= {1'b0, wr_pos} + 5'd1;
                            rewrite_all    <= 1'b0;
                            state          <= SETUP;
                        end
`ifdef HPDL_SCROLL_EN
                        else if (is_print) begin
                            for (int i = 0; i < NUM_POS - 1; i++) buffer[i] <= buffer[i+1];
                            buffer[NUM_POS-1] <= folded[6:0];
                            pos               <= '0;
                            rewrite_all       <= 1'b1;
                            state             <= NEXT;
                        end
`endif
                        else if (char_i == CHAR_CR) begin
                            cursor <= '0;
                        end else if (char_i == CHAR_FF) begin
                            for (int i = 0; i < NUM_POS; i++) buffer[i] <= CHAR_SPACE;
                            cursor      <= '0;
                            pos         <= '0;
                            rewrite_all <= 1'b1;
                            state       <= NEXT;
                        end
                    end
                end
                SETUP: begin
                    if (done) begin
                        if (rewrite_all && (pos != 4'd15)) begin
                            pos   <= pos + 4'd1;
                            state <= NEXT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                NEXT: state <= SETUP;
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_hpdl1414_writer.sv
// Self-checking bench for hpdl1414_writer: a bus monitor rebuilds each completed strobe and
// compares it against a screen/cursor model of the terminal rules. Honours HPDL_SCROLL_EN.
module tb_hpdl1414_writer;

    localparam int SETUP = 2;
    localparam int WR    = 3;
    localparam int HOLD  = 2;

    logic       CLK_i = 1'b0;
    logic       RST_i = 1'b1;
    logic [7:0] char_i = 8'h00;
    logic       char_valid_i = 1'b0;
    logic       char_ready_o;
    logic [6:0] hpdl_d_o;
    logic [1:0] hpdl_a_o;
    logic [3:0] hpdl_wr_n_o;
    logic       busy_o;

    hpdl1414_writer #(
        .SETUP_CYC (SETUP),
        .WR_CYC    (WR),
        .HOLD_CYC  (HOLD)
    ) dut (
        .CLK_i        (CLK_i),
        .RST_i        (RST_i),
        .char_i       (char_i),
        .char_valid_i (char_valid_i),
        .char_ready_o (char_ready_o),
        .hpdl_d_o     (hpdl_d_o),
        .hpdl_a_o     (hpdl_a_o),
        .hpdl_wr_n_o  (hpdl_wr_n_o),
        .busy_o       (busy_o)
    );

    always #5 CLK_i = ~CLK_i;

    typedef struct {
        int pos;
        int data;
        int wr_n;
        int setup;
        int width;
        int hold;
        int multi;
        int moved;
    } obs_t;

    typedef struct {
        int pos;
        int data;
    } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t obs_q[$];
    exp_t exp_q[$];
    int   m_screen [16];
    int   m_cursor;
    int   scr_obs [16];
    logic [6:0] lat_d;
    logic [1:0] lat_a;

    // Bus monitor: one record per WR pulse, with setup/hold measured as cycles of unchanged d/a.
    obs_t       cur;
    bit         in_low;
    bit         in_hold;
    int         stable;
    int         cur_a;
    logic [6:0] prev_d;
    logic [1:0] prev_a;

    always @(negedge CLK_i) begin
        if (RST_i) begin
            in_low  = 1'b0;
            in_hold = 1'b0;
            stable  = 0;
        end else begin
            if (hpdl_d_o === prev_d && hpdl_a_o === prev_a) stable++;
            else stable = 1;
            if (hpdl_wr_n_o !== 4'hF) begin
                if (!in_low) begin
                    if (in_hold) begin
                        obs_q.push_back(cur);
                        in_hold = 1'b0;
                    end
                    cur = '{default: 0};
                    for (int i = 3; i >= 0; i--)
                        if (hpdl_wr_n_o[i] == 1'b0) cur.pos = i * 4 + 3 - int'(hpdl_a_o);
                    cur.data  = int'(hpdl_d_o);
                    cur_a     = int'(hpdl_a_o);
                    cur.wr_n  = int'(hpdl_wr_n_o);
                    cur.setup = stable - 1;
                    in_low    = 1'b1;
                end
                cur.width++;
                if (!$onehot(~hpdl_wr_n_o)) cur.multi = 1;
                if (int'(hpdl_d_o) != cur.data || int'(hpdl_a_o) != cur_a || int'(hpdl_wr_n_o) != cur.wr_n)
                    cur.moved = 1;
            end else begin
                if (in_low) begin
                    in_low  = 1'b0;
                    in_hold = 1'b1;
                end
                if (in_hold) begin
                    if (int'(hpdl_d_o) == cur.data && int'(hpdl_a_o) == cur_a) cur.hold++;
                    else begin
                        obs_q.push_back(cur);
                        in_hold = 1'b0;
                    end
                end
            end
        end
        prev_d = hpdl_d_o;
        prev_a = hpdl_a_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input int p, input int d);
        exp_t e;
        e.pos  = p;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Reference terminal: screen contents and cursor, evolved by the byte rules.
    task automatic model_reset();
        m_cursor = 0;
        for (int p = 0; p < 16; p++) begin
            m_screen[p] = 'h20;
            expect_write(p, 'h20);
        end
    endtask

    task automatic model_apply(input logic [7:0] c);
        int b;
        b = int'(c);
        if (b >= 'h60 && b <= 'h7E) b = b - 'h20;
        if (b >= 'h20 && b <= 'h5F) begin
            if (m_cursor < 16) begin
                m_screen[m_cursor] = b;
                expect_write(m_cursor, b);
                m_cursor++;
            end else begin
`ifdef HPDL_SCROLL_EN
                for (int p = 0; p < 15; p++) m_screen[p] = m_screen[p+1];
                m_screen[15] = b;
                for (int p = 0; p < 16; p++) expect_write(p, m_screen[p]);
`else
                m_screen[0] = b;
                expect_write(0, b);
                m_cursor = 1;
`endif
            end
        end else if (c == 8'h0D) begin
            m_cursor = 0;
        end else if (c == 8'h0C) begin
            m_cursor = 0;
            for (int p = 0; p < 16; p++) begin
                m_screen[p] = 'h20;
                expect_write(p, 'h20);
            end
        end
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n;
        n = 0;
        while (char_ready_o !== 1'b1 && n < budget) begin
            @(negedge CLK_i);
            n++;
        end
        check({tag, " ready within budget"}, 32'(char_ready_o), 32'd1);
    endtask

    task automatic send(input logic [7:0] c);
        wait_ready($sformatf("pre-send 0x%0h", c), 400);
        char_i       = c;
        char_valid_i = 1'b1;
        @(posedge CLK_i);
        #1;
        lat_d = hpdl_d_o;
        lat_a = hpdl_a_o;
        @(negedge CLK_i);
        char_valid_i = 1'b0;
        model_apply(c);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        wait_ready(tag, 400);
        @(negedge CLK_i);
        check({tag, " write count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s w%0d pos", tag, i), obs_q[i].pos, exp_q[i].pos);
            check($sformatf("%s w%0d data", tag, i), obs_q[i].data, exp_q[i].data);
            check($sformatf("%s w%0d wr_n", tag, i), obs_q[i].wr_n, 15 & ~(1 << (exp_q[i].pos / 4)));
            check($sformatf("%s w%0d setup", tag, i), obs_q[i].setup, SETUP);
            check($sformatf("%s w%0d width", tag, i), obs_q[i].width, WR);
            check($sformatf("%s w%0d hold", tag, i), obs_q[i].hold, HOLD);
            check($sformatf("%s w%0d multi-low", tag, i), obs_q[i].multi, 0);
            check($sformatf("%s w%0d bus moved", tag, i), obs_q[i].moved, 0);
            if (obs_q[i].pos >= 0 && obs_q[i].pos < 16) scr_obs[obs_q[i].pos] = obs_q[i].data;
        end
        check({tag, " idle d"}, 32'(hpdl_d_o), 32'd0);
        check({tag, " idle a"}, 32'(hpdl_a_o), 32'd0);
        check({tag, " idle wr_n"}, 32'(hpdl_wr_n_o), 32'hF);
        check({tag, " idle busy"}, 32'(busy_o), 32'd0);
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] c;
        int         n;

        // Reset state
        repeat (3) @(negedge CLK_i);
        check("reset wr_n", 32'(hpdl_wr_n_o), 32'hF);
        check("reset d", 32'(hpdl_d_o), 32'd0);
        check("reset a", 32'(hpdl_a_o), 32'd0);
        check("reset ready", 32'(char_ready_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd1);
        RST_i = 1'b0;
        model_reset();
        compare_writes("init");

        // 'A' at cursor 0
        send(8'h41);
        check("A latency d", 32'(lat_d), 32'h41);
        check("A latency a", 32'(lat_a), 32'd3);
        compare_writes("A");

        // Advance cursor to 5, then lower-case 'q' folds to 'Q'
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom_range(32, 126)));
            compare_writes($sformatf("fill%0d", i));
        end
        send(8'h71);
        check("q latency d", 32'(lat_d), 32'h51);
        check("q latency a", 32'(lat_a), 32'd2);
        compare_writes("q");

        // CR then BEL: no activity; next printable lands on p0
        send(8'h0D);
        compare_writes("CR");
        send(8'h07);
        compare_writes("BEL");
        send(8'h5A);
        compare_writes("Z after CR");

        // Form feed
        send(8'h0C);
        compare_writes("FF");

        // 17 characters: wrap or scroll at the end of the line
        for (int i = 0; i < 17; i++) begin
            send(8'(8'h41 + i));
            compare_writes($sformatf("line%0d", i));
        end
`ifdef HPDL_SCROLL_EN
        for (int p = 0; p < 16; p++) check($sformatf("scroll p%0d", p), scr_obs[p], 'h42 + p);
`else
        check("wrap p0", scr_obs[0], 'h51);
        check("wrap p1", scr_obs[1], 'h42);
`endif

        // Randomised byte stream
        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 19);
            if (n == 0) c = 8'h0D;
            else if (n == 1) c = 8'h0C;
            else if (n < 6) c = 8'($urandom_range(0, 255));
            else c = 8'($urandom_range(32, 126));
            send(c);
            compare_writes($sformatf("rnd%0d 0x%0h", i, c));
        end
        for (int p = 0; p < 16; p++) check($sformatf("screen p%0d", p), scr_obs[p], m_screen[p]);

        // Reset in the middle of a strobe
        wait_ready("abort pre", 400);
        char_i       = 8'h58;
        char_valid_i = 1'b1;
        @(posedge CLK_i);
        @(negedge CLK_i);
        char_valid_i = 1'b0;
        n = 0;
        while (hpdl_wr_n_o === 4'hF && n < 20) begin
            @(negedge CLK_i);
            n++;
        end
        check("abort strobe seen", 32'(hpdl_wr_n_o != 4'hF), 32'd1);
        #2;
        RST_i = 1'b1;
        #1;
        check("abort wr_n", 32'(hpdl_wr_n_o), 32'hF);
        check("abort d", 32'(hpdl_d_o), 32'd0);
        check("abort ready", 32'(char_ready_o), 32'd0);
        check("abort busy", 32'(busy_o), 32'd1);
        repeat (2) @(negedge CLK_i);
        obs_q.delete();
        exp_q.delete();
        RST_i = 1'b0;
        model_reset();
        compare_writes("re-init");
        send(8'h61);
        compare_writes("a after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
